// File: rtl/polar_fg_pe_if.sv
`timescale 1ns/1ps
// Stream bundle for the polar f/g PE: LLR pair input beats and
// magnitude/sign output beats with frame index and saturation status.
interface polar_fg_pe_if #(
    parameter int CW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    llr_a;
    logic [7:0]    llr_b;
    logic          mode;
    logic          u_bit;

    logic          out_valid;
    logic          out_ready;
    logic [7:0]    mag;
    logic          sgn;
    logic [CW-1:0] pair_idx;
    logic          out_last;
    logic          sat_flag;

    // master = surrounding datapath (feeds LLRs, consumes results), slave = the PE
    modport master (
        output in_valid, llr_a, llr_b, mode, u_bit, out_ready,
        input  in_ready, out_valid, mag, sgn, pair_idx, out_last, sat_flag
    );

    modport slave (
        input  in_valid, llr_a, llr_b, mode, u_bit, out_ready,
        output in_ready, out_valid, mag, sgn, pair_idx, out_last, sat_flag
    );
endinterface

// File: rtl/polar_fg_pe.sv
`timescale 1ns/1ps
// Polar SC f (min-sum) / g (partial-sum) node PE with frame index and sticky saturation flag.
// 2-cycle latency, 1 beat/cycle; out_valid && !out_ready freezes both stages and drops in_ready.
module polar_fg_pe #(
    parameter int N_PAIRS = 16,
    parameter int CW      = $clog2(N_PAIRS)
) (
    input  logic         clk,
    input  logic         rst,
    polar_fg_pe_if.slave pe
);
    localparam logic [CW-1:0] LAST_IDX = CW'(N_PAIRS - 1);

    typedef struct packed {
        logic       vld;
        logic       mode;
        logic       sx;
        logic       sat;
        logic [6:0] abs_a;
        logic [6:0] abs_b;
        logic [8:0] sum;
    } s1_t;

    typedef struct packed {
        logic       vld;
        logic       sgn;
        logic       sat;
        logic [6:0] mag;
    } s2_t;

    s1_t           s1_d, s1_q;
    s2_t           s2_d, s2_q;
    logic [CW-1:0] idx_d, idx_q;
    logic          sat_flag_d, sat_flag_q;
    logic          clr_pend_d, clr_pend_q;

    logic              adv;
    logic              xfer_out;
    logic              last_beat;
    logic [7:0]        abs_a;
    logic [7:0]        abs_b;
    logic signed [8:0] a_ext;
    logic signed [8:0] b_ext;
    logic signed [8:0] g_sum;
    logic [6:0]        f_min;

    // {saturated, |v|} with |-128| clamped to 127
    function automatic logic [7:0] abs_sat(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h80) begin
            r = {1'b1, 7'h7f};
        end else if (v[7]) begin
            r = {1'b0, 7'(-v)};
        end else begin
            r = {1'b0, v[6:0]};
        end
        return r;
    endfunction

    assign adv       = !s2_q.vld || pe.out_ready;
    assign xfer_out  = s2_q.vld && pe.out_ready;
    assign last_beat = s2_q.vld && (idx_q == LAST_IDX);

    assign pe.in_ready  = adv && !rst;
    assign pe.out_valid = s2_q.vld;
    assign pe.mag       = {1'b0, s2_q.mag};
    assign pe.sgn       = s2_q.sgn;
    assign pe.pair_idx  = idx_q;
    assign pe.out_last  = last_beat;
    assign pe.sat_flag  = sat_flag_q;

    always_comb begin
        abs_a = abs_sat(pe.llr_a);
        abs_b = abs_sat(pe.llr_b);
        a_ext = {pe.llr_a[7], pe.llr_a};
        b_ext = {pe.llr_b[7], pe.llr_b};
        s1_d  = s1_q;
        if (adv) begin
            s1_d     = '0;
            s1_d.vld = pe.in_valid;
            if (pe.in_valid) begin
                s1_d.mode = pe.mode;
                if (pe.mode) begin
                    s1_d.sum = pe.u_bit ? 9'(b_ext - a_ext) : 9'(b_ext + a_ext);
                end else begin
                    s1_d.abs_a = abs_a[6:0];
                    s1_d.abs_b = abs_b[6:0];
                    s1_d.sat   = abs_a[7] || abs_b[7];
                    s1_d.sx    = pe.llr_a[7] ^ pe.llr_b[7];
                end
            end
        end
    end

    always_comb begin
        g_sum = s1_q.sum;
        f_min = (s1_q.abs_a < s1_q.abs_b) ? s1_q.abs_a : s1_q.abs_b;
        s2_d  = s2_q;
        if (adv) begin
            s2_d     = '0;
            s2_d.vld = s1_q.vld;
            if (s1_q.vld && !s1_q.mode) begin
                // a zero magnitude always reports positive sign
                s2_d.mag = f_min;
                s2_d.sgn = s1_q.sx && (f_min != 7'd0);
                s2_d.sat = s1_q.sat;
            end else if (s1_q.vld) begin
                if (g_sum > 9'sd127) begin
                    s2_d.mag = 7'd127;
                    s2_d.sat = 1'b1;
                end else if (g_sum < -9'sd127) begin
                    s2_d.mag = 7'd127;
                    s2_d.sgn = 1'b1;
                    s2_d.sat = 1'b1;
                end else if (g_sum < 9'sd0) begin
                    s2_d.mag = 7'(-g_sum);
                    s2_d.sgn = 1'b1;
                end else begin
                    s2_d.mag = g_sum[6:0];
                end
            end
        end
    end

    // Flag clears on the first transfer after a frame end, but a saturating beat re-arms it.
    always_comb begin
        idx_d      = idx_q;
        clr_pend_d = clr_pend_q;
        sat_flag_d = sat_flag_q;
        if (xfer_out) begin
            idx_d      = (idx_q == LAST_IDX) ? '0 : idx_q + CW'(1);
            clr_pend_d = last_beat;
            if (clr_pend_q) begin
                sat_flag_d = s2_q.sat;
            end
        end
        if (adv && s2_d.vld && s2_d.sat) begin
            sat_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q       <= '0;
            s2_q       <= '0;
            idx_q      <= '0;
            sat_flag_q <= 1'b0;
            clr_pend_q <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            idx_q      <= idx_d;
            sat_flag_q <= sat_flag_d;
            clr_pend_q <= clr_pend_d;
        end
    end
endmodule

// File: tb/tb_polar_fg_pe.sv
`timescale 1ns/1ps
// Scoreboard bench for polar_fg_pe: directed beats push expected results,
// an independent monitor pops and compares on every output transfer.
module tb_polar_fg_pe;
    localparam int N_PAIRS = 16;
    localparam int CW      = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    polar_fg_pe_if #(.CW(CW)) bus ();

    polar_fg_pe #(.N_PAIRS(N_PAIRS), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .pe  (bus)
    );

    typedef struct {
        int   mag;
        logic sgn;
        int   idx;
        logic last;
        logic sat;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: compares every output transfer and holds mag/sgn across stalls.
    initial begin : monitor
        exp_t       e;
        logic       stalled;
        logic [7:0] h_mag;
        logic       h_sgn;
        stalled = 1'b0;
        h_mag   = '0;
        h_sgn   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled && bus.out_valid) begin
                    check("stall_mag_stable", int'(bus.mag), int'(h_mag));
                    check("stall_sgn_stable", int'(bus.sgn), int'(h_sgn));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got beat idx %0d mag %0d, expected none",
                                 bus.pair_idx, bus.mag);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("beat%0d_mag", e.idx), int'(bus.mag), e.mag);
                        check($sformatf("beat%0d_sgn", e.idx), int'(bus.sgn), int'(e.sgn));
                        check($sformatf("beat%0d_idx", e.idx), int'(bus.pair_idx), e.idx);
                        check($sformatf("beat%0d_last", e.idx), int'(bus.out_last), int'(e.last));
                        check($sformatf("beat%0d_sat", e.idx), int'(bus.sat_flag), int'(e.sat));
                    end
                end
                stalled = bus.out_valid && !bus.out_ready;
                h_mag   = bus.mag;
                h_sgn   = bus.sgn;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input int a, input int b, input logic m, input logic u,
                        input int emag, input logic esgn, input int eidx,
                        input logic elast, input logic esat, input logic track = 1'b1);
        exp_t e;
        int   waited;
        logic ok;
        bus.llr_a    = 8'(a);
        bus.llr_b    = 8'(b);
        bus.mode     = m;
        bus.u_bit    = u;
        bus.in_valid = 1'b1;
        if (track) begin
            e.mag  = emag;
            e.sgn  = esgn;
            e.idx  = eidx;
            e.last = elast;
            e.sat  = esat;
            exp_q.push_back(e);
        end
        ok     = 1'b0;
        waited = 0;
        while (!ok && waited < 50) begin
            @(negedge clk);
            ok = bus.in_ready;
            waited++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready low for %0d cycles, expected accept", waited);
        end
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_mag", int'(bus.mag), 0);
        check("rst_sgn", int'(bus.sgn), 0);
        check("rst_pair_idx", int'(bus.pair_idx), 0);
        check("rst_out_last", int'(bus.out_last), 0);
        check("rst_sat_flag", int'(bus.sat_flag), 0);
        check("rst_in_ready", int'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("release_in_ready", int'(bus.in_ready), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 60) begin
            @(posedge clk);
            w++;
        end
        check("drain_pending", exp_q.size(), 0);
        #1;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.llr_a     = '0;
        bus.llr_b     = '0;
        bus.mode      = 1'b0;
        bus.u_bit     = 1'b0;
        bus.out_ready = 1'b1;

        // Arithmetic cases, zero results, saturation, and latency of the first beat.
        do_reset();
        send(-20, 35, 1'b0, 1'b0, 20, 1'b1, 0, 1'b0, 1'b0);
        @(negedge clk);
        check("latency_1cyc_no_out", int'(bus.out_valid), 0);
        @(negedge clk);
        check("latency_2cyc_out", int'(bus.out_valid), 1);
        @(posedge clk);
        #1;
        send(-20, 35, 1'b1, 1'b1, 55, 1'b0, 1, 1'b0, 1'b0);
        send(-20, 35, 1'b1, 1'b0, 15, 1'b0, 2, 1'b0, 1'b0);
        send(-5, 0, 1'b0, 1'b1, 0, 1'b0, 3, 1'b0, 1'b0);
        send(100, 100, 1'b1, 1'b0, 127, 1'b0, 4, 1'b0, 1'b1);
        send(-128, -128, 1'b0, 1'b0, 127, 1'b0, 5, 1'b0, 1'b1);
        send(100, -100, 1'b1, 1'b1, 127, 1'b1, 6, 1'b0, 1'b1);
        send(5, 5, 1'b1, 1'b1, 0, 1'b0, 7, 1'b0, 1'b1);
        send(-3, -128, 1'b0, 1'b0, 3, 1'b0, 8, 1'b0, 1'b1);
        send(-128, -128, 1'b1, 1'b0, 127, 1'b1, 9, 1'b0, 1'b1);
        send(-128, 127, 1'b1, 1'b1, 127, 1'b0, 10, 1'b0, 1'b1);
        drain();

        // Backpressure: downstream stalls for 4 cycles while 5 beats stream in.
        do_reset();
        fork
            begin
                send(10, -7, 1'b0, 1'b0, 7, 1'b1, 0, 1'b0, 1'b0);
                send(-1, -1, 1'b0, 1'b0, 1, 1'b0, 1, 1'b0, 1'b0);
                send(60, -70, 1'b1, 1'b0, 10, 1'b1, 2, 1'b0, 1'b0);
                send(-50, -50, 1'b1, 1'b1, 0, 1'b0, 3, 1'b0, 1'b0);
                send(127, -127, 1'b0, 1'b0, 127, 1'b1, 4, 1'b0, 1'b0);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    check("bp_in_ready_low", int'(bus.in_ready), 0);
                    check("bp_out_valid_held", int'(bus.out_valid), 1);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Full frame plus two beats: wrap, out_last, sat_flag clear after frame end.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            if (i == 3)
                send(-128, -128, 1'b0, 1'b0, 127, 1'b0, i % 16, 1'b0, 1'b1);
            else
                send(i + 1, -(i + 20), 1'b0, 1'b0, i + 1, 1'b1, i % 16,
                     (i == 15), (i >= 3 && i <= 16));
        end
        drain();

        // Reset mid-frame after 7 outputs: in-flight beats must vanish.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i == 2)
                send(-128, -128, 1'b0, 1'b0, 127, 1'b0, i, 1'b0, 1'b1, (i < 7));
            else
                send(-(i + 2), 40, 1'b0, 1'b0, i + 2, 1'b1, i, 1'b0, (i >= 2), (i < 7));
        end
        do_reset();
        check("reset_flush_pending", exp_q.size(), 0);
        repeat (6) @(posedge clk);
        #1;
        send(7, -9, 1'b0, 1'b0, 7, 1'b1, 0, 1'b0, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
